branch_pc_unit: RTL and testbench

- Program-counter and branch-resolution stage sitting directly downstream of the 64-bit ALU in the single-cycle RISC-V core.
- Consumes the ALU result and its zero/le_flag/ge_flag outputs together with decoded control, and registers the next PC.
- Runs a small run-control state machine (IDLE/RUN/HALT) and keeps retired-instruction and taken-branch counters for debug and testbench use.

---
 rtl/branch_pc_unit.sv | 115 +++++++++++
 tb/tb_branch_pc_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// Program counter, branch resolution and IDLE/RUN/HALT run control for the
// single-cycle core; sits directly behind the ALU and registers the next PC.
module branch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic [63:0]      imm,
  input  logic [63:0]      alu_result,
  input  logic             zero,
  input  logic             le_flag,
  input  logic             ge_flag,
  output logic [63:0]      pc,
  output logic [63:0]      pc_plus4,
  output logic             taken,
  output logic             running,
  output logic             halted,
  output logic             misalign,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state;
  logic        cond_c;
  logic        redirect_c;
  logic        misalign_c;
  logic [63:0] pc_imm_c;
  logic [63:0] target_c;

  // Branch condition; signed compares are not available from the ALU.
  always_comb begin
    cond_c = 1'b0;
    case (funct3)
      3'b000:  cond_c = zero;
      3'b001:  cond_c = ~zero;
      3'b110:  cond_c = le_flag & ~zero;
      3'b111:  cond_c = ge_flag;
      default: cond_c = 1'b0;
    endcase
  end

  assign pc_plus4   = pc + 64'd4;
  assign pc_imm_c   = pc + imm;
  assign running    = (state == S_RUN);
  assign halted     = (state == S_HALT);
  assign redirect_c = jalr | jump | (branch & cond_c);

  // A halting instruction suppresses any redirect it carries.
  assign taken      = running & ~stall & ~halt & redirect_c;

  always_comb begin
    target_c = pc_plus4;
    if (jalr)
      target_c = alu_result & ~64'h1;
    else if (jump || (branch && cond_c))
      target_c = pc_imm_c;
  end

  assign misalign_c = taken & (target_c[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      instr_count <= '0;
      taken_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start)
            state <= S_RUN;
        end
        S_RUN: begin
          if (!stall) begin
            if (halt) begin
              instr_count <= instr_count + CNT_W'(1);
              state       <= S_HALT;
            end else if (misalign_c) begin
              // Faulting redirect does not retire; PC stays on the culprit.
              misalign <= 1'b1;
              state    <= S_HALT;
            end else begin
              pc          <= target_c;
              instr_count <= instr_count + CNT_W'(1);
              if (taken)
                taken_count <= taken_count + CNT_W'(1);
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: a default-reset instance and a
// wrap-around-reset instance share stimulus, each held in reset while unused.
module tb_branch_pc_unit;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ic;
    logic [31:0] tc;
  } exp_t;

  logic        clk;
  logic        reset_n0, reset_n1;
  logic        start, stall, halt, branch, jump, jalr;
  logic [2:0]  funct3;
  logic [63:0] imm, alu_result;
  logic        zero, le_flag, ge_flag;

  logic [63:0] pc0, pc_plus4_0, pc1, pc_plus4_1;
  logic        taken0, running0, halted0, misalign0;
  logic        taken1, running1, halted1, misalign1;
  logic [31:0] ic0, tc0, ic1, tc1;

  int unsigned total, bad;
  exp_t        sb_q[$];
  exp_t        e;
  logic [63:0] m_pc;
  logic [31:0] m_ic, m_tc;

  branch_pc_unit dut0 (
    .clk(clk), .reset_n(reset_n0), .start(start), .stall(stall), .halt(halt),
    .branch(branch), .jump(jump), .jalr(jalr), .funct3(funct3), .imm(imm),
    .alu_result(alu_result), .zero(zero), .le_flag(le_flag), .ge_flag(ge_flag),
    .pc(pc0), .pc_plus4(pc_plus4_0), .taken(taken0), .running(running0),
    .halted(halted0), .misalign(misalign0), .instr_count(ic0), .taken_count(tc0)
  );

  branch_pc_unit #(.RESET_PC(WRAP_PC), .CNT_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n1), .start(start), .stall(stall), .halt(halt),
    .branch(branch), .jump(jump), .jalr(jalr), .funct3(funct3), .imm(imm),
    .alu_result(alu_result), .zero(zero), .le_flag(le_flag), .ge_flag(ge_flag),
    .pc(pc1), .pc_plus4(pc_plus4_1), .taken(taken1), .running(running1),
    .halted(halted1), .misalign(misalign1), .instr_count(ic1), .taken_count(tc1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    start = 0; stall = 0; halt = 0; branch = 0; jump = 0; jalr = 0;
    funct3 = 3'b000; imm = '0; alu_result = '0; zero = 0; le_flag = 0; ge_flag = 0;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset_n0 = 1; reset_n1 = 1;
    #1;
    reset_n0 = 0; reset_n1 = 0;
    #2;
    total++;
    if (pc0 !== 64'h0 || ic0 !== 32'd0 || tc0 !== 32'd0 || running0 !== 1'b0 ||
        halted0 !== 1'b0 || misalign0 !== 1'b0) begin
      bad++;
      $display("FAIL reset0: pc=%h ic=%0d tc=%0d run=%b halt=%b mis=%b expected all zero",
               pc0, ic0, tc0, running0, halted0, misalign0);
    end
    total++;
    if (pc1 !== WRAP_PC || pc_plus4_1 !== 64'h0) begin
      bad++;
      $display("FAIL reset1_wrap: pc=%h pc_plus4=%h expected %h / 0", pc1, pc_plus4_1, WRAP_PC);
    end
    tick();
    reset_n0 = 1;
    m_pc = 64'h0; m_ic = 0; m_tc = 0;
  endtask

  task automatic test_sequential();
    start = 1;
    tick();
    start = 0;
    total++;
    if (running0 !== 1'b1 || pc0 !== 64'h0) begin
      bad++;
      $display("FAIL start: running=%b pc=%h expected 1 / 0", running0, pc0);
    end
    for (int i = 0; i < 3; i++) begin
      m_pc = m_pc + 64'd4; m_ic++;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
        bad++;
        $display("FAIL seq%0d: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
                 i, pc0, ic0, tc0, e.pc, e.ic, e.tc);
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3_t [10];
    logic       z_t  [10];
    logic       le_t [10];
    logic       ge_t [10];
    logic       c_t  [10];
    f3_t = '{3'b001, 3'b001, 3'b110, 3'b110, 3'b111, 3'b111, 3'b100, 3'b101, 3'b010, 3'b011};
    z_t  = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b0};
    le_t = '{1'b0,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1};
    ge_t = '{1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1,   1'b1,   1'b1};
    c_t  = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};

    for (int r = 0; r < 2; r++) begin
      jalr = 1; alu_result = 64'h100;
      m_pc = 64'h100; m_ic++; m_tc++;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      jalr = 0;
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
        bad++;
        $display("FAIL jalr_0x100: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
                 pc0, ic0, tc0, e.pc, e.ic, e.tc);
      end
      branch = 1; funct3 = 3'b000; imm = 64'h40; zero = (r == 0);
      #1;
      total++;
      if (taken0 !== (r == 0)) begin
        bad++;
        $display("FAIL beq_taken%0d: got %b expected %b", r, taken0, (r == 0));
      end
      m_pc = (r == 0) ? 64'h140 : 64'h104; m_ic++;
      if (r == 0) m_tc++;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      branch = 0; zero = 0;
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
        bad++;
        $display("FAIL beq_pc%0d: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
                 r, pc0, ic0, tc0, e.pc, e.ic, e.tc);
      end
    end

    for (int i = 0; i < 10; i++) begin
      branch = 1; imm = 64'h10;
      funct3 = f3_t[i]; zero = z_t[i]; le_flag = le_t[i]; ge_flag = ge_t[i];
      #1;
      total++;
      if (taken0 !== c_t[i]) begin
        bad++;
        $display("FAIL cond_f3_%0d_row%0d: taken got %b expected %b", f3_t[i], i, taken0, c_t[i]);
      end
      m_pc = m_pc + (c_t[i] ? 64'h10 : 64'h4); m_ic++;
      if (c_t[i]) m_tc++;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
        bad++;
        $display("FAIL cond_pc_row%0d: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
                 i, pc0, ic0, tc0, e.pc, e.ic, e.tc);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_jalr_jump();
    logic [63:0] imm_t [3];
    logic [63:0] pc_t  [3];
    imm_t = '{64'h8, 64'h20, -64'sd32};
    pc_t  = '{64'h2000, 64'h2020, 64'h2000};
    for (int i = 0; i < 3; i++) begin
      jalr = (i == 0); jump = 1; alu_result = 64'h2001; imm = imm_t[i];
      #1;
      total++;
      if (taken0 !== 1'b1) begin
        bad++;
        $display("FAIL jump_taken%0d: got %b expected 1", i, taken0);
      end
      m_pc = pc_t[i]; m_ic++; m_tc++;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
        bad++;
        $display("FAIL jump_pc%0d: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
                 i, pc0, ic0, tc0, e.pc, e.ic, e.tc);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_stall();
    branch = 1; funct3 = 3'b000; zero = 1; imm = 64'h80; stall = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) stall = 0;
      if (i == 5) branch = 0;
      #1;
      total++;
      if (taken0 !== (i == 4)) begin
        bad++;
        $display("FAIL stall_taken%0d: got %b expected %b", i, taken0, (i == 4));
      end
      if (i == 4) begin
        m_pc = m_pc + 64'h80; m_ic++; m_tc++;
      end else if (i == 5) begin
        m_pc = m_pc + 64'h4; m_ic++;
      end
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc || running0 !== 1'b1) begin
        bad++;
        $display("FAIL stall_pc%0d: got pc=%h ic=%0d tc=%0d run=%b expected pc=%h ic=%0d tc=%0d run=1",
                 i, pc0, ic0, tc0, running0, e.pc, e.ic, e.tc);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_async_reset();
    jalr = 1; alu_result = 64'h500;
    m_pc = 64'h500; m_ic++; m_tc++;
    sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
    tick();
    jalr = 0;
    e = sb_q.pop_front();
    total++;
    if (pc0 !== e.pc || ic0 !== e.ic || tc0 !== e.tc) begin
      bad++;
      $display("FAIL pre_reset_pc: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
               pc0, ic0, tc0, e.pc, e.ic, e.tc);
    end
    @(negedge clk);
    reset_n0 = 0;
    #1;
    total++;
    if (pc0 !== 64'h0 || ic0 !== 32'd0 || tc0 !== 32'd0 || running0 !== 1'b0 || halted0 !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: pc=%h ic=%0d tc=%0d run=%b halt=%b expected 0/0/0/0/0",
               pc0, ic0, tc0, running0, halted0);
    end
    tick();
    reset_n0 = 1;
    m_pc = 64'h0; m_ic = 0; m_tc = 0;
    start = 1;
    tick();
    start = 0;
    total++;
    if (running0 !== 1'b1 || pc0 !== 64'h0) begin
      bad++;
      $display("FAIL restart: running=%b pc=%h expected 1 / 0", running0, pc0);
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 2; i++) begin
      jalr = (i == 0); alu_result = 64'h2002;
      sb_q.push_back('{pc: m_pc, ic: m_ic, tc: m_tc});
      tick();
      e = sb_q.pop_front();
      total++;
      if (pc0 !== e.pc || ic0 !== e.ic || misalign0 !== 1'b1 || halted0 !== 1'b1 || running0 !== 1'b0) begin
        bad++;
        $display("FAIL misalign%0d: got pc=%h ic=%0d mis=%b halt=%b run=%b expected pc=%h ic=%0d mis=1 halt=1 run=0",
                 i, pc0, ic0, misalign0, halted0, running0, e.pc, e.ic);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_wrap_halt();
    reset_n0 = 0;
    clear_ctrl();
    tick();
    reset_n1 = 1;
    start = 1;
    tick();
    start = 0;
    total++;
    if (running1 !== 1'b1 || pc1 !== WRAP_PC) begin
      bad++;
      $display("FAIL wrap_start: running=%b pc=%h expected 1 / %h", running1, pc1, WRAP_PC);
    end
    sb_q.push_back('{pc: 64'h0, ic: 32'd1, tc: 32'd0});
    tick();
    e = sb_q.pop_front();
    total++;
    if (pc1 !== e.pc || ic1 !== e.ic || tc1 !== e.tc) begin
      bad++;
      $display("FAIL wrap_pc: got pc=%h ic=%0d tc=%0d expected pc=%h ic=%0d tc=%0d",
               pc1, ic1, tc1, e.pc, e.ic, e.tc);
    end
    halt = 1; jump = 1; imm = 64'h40;
    #1;
    total++;
    if (taken1 !== 1'b0) begin
      bad++;
      $display("FAIL halt_taken: got %b expected 0", taken1);
    end
    sb_q.push_back('{pc: 64'h0, ic: 32'd2, tc: 32'd0});
    tick();
    clear_ctrl();
    e = sb_q.pop_front();
    total++;
    if (pc1 !== e.pc || ic1 !== e.ic || tc1 !== e.tc || halted1 !== 1'b1) begin
      bad++;
      $display("FAIL halt_pc: got pc=%h ic=%0d tc=%0d halted=%b expected pc=%h ic=%0d tc=%0d halted=1",
               pc1, ic1, tc1, halted1, e.pc, e.ic, e.tc);
    end
    start = 1;
    tick();
    start = 0;
    tick();
    total++;
    if (halted1 !== 1'b1 || running1 !== 1'b0 || pc1 !== 64'h0 || ic1 !== 32'd2 ||
        pc_plus4_1 !== 64'h4 || misalign1 !== 1'b0) begin
      bad++;
      $display("FAIL halt_hold: halt=%b run=%b pc=%h ic=%0d pc4=%h mis=%b expected 1/0/0/2/4/0",
               halted1, running1, pc1, ic1, pc_plus4_1, misalign1);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_jump();
    test_stall();
    test_async_reset();
    test_misalign();
    test_wrap_halt();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
